pc_fetch_unit: RTL and testbench

Program-counter and fetch-sequencing stage directly upstream of the word-addressed instruction memory. Holds the PC, drives it to the memory address input, and computes the next PC: sequential, branch, or jump. It also observes the fetched instruction to detect HALT, flags out-of-range fetches, and counts retired fetches. Single-cycle core: one instruction per clock while running.

---
 rtl/pc_fetch_unit.sv | 121 ++++++++++++
 tb/tb_pc_fetch_unit.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// Program counter and fetch sequencer for a single-cycle core.
// Drives the word address to instruction memory and selects the next PC
// (sequential, relative branch or absolute jump). It also stops on a HALT
// encoding, flags fetches outside the memory, and counts retired fetches.
module pc_fetch_unit #(
  parameter int                    addWidth   = 6,
  parameter int                    dataWidth  = 32,
  parameter logic [dataWidth-1:0]  RESET_PC   = '0,
  parameter logic [dataWidth-1:0]  HALT_INSTR = 32'hFFFF_FFFF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 branch_taken,
  input  logic [15:0]          branch_offset,
  input  logic                 jump,
  input  logic [25:0]          jump_target,
  input  logic [dataWidth-1:0] Instr,
  output logic [dataWidth-1:0] PC,
  output logic [dataWidth-1:0] pc_plus1,
  output logic                 valid,
  output logic                 halted,
  output logic                 fault,
  output logic [dataWidth-1:0] instr_count
);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2,
    FAULT  = 2'd3
  } state_t;

  state_t                 state_q;
  logic [dataWidth-1:0]   pc_q;
  logic [dataWidth-1:0]   cnt_q;
  logic                   valid_q;
  logic                   halted_q;
  logic                   fault_q;

  logic [dataWidth-1:0]        pc_inc;
  logic signed [dataWidth-1:0] br_off_s;
  logic signed [dataWidth-1:0] br_target_s;
  logic [dataWidth-1:0]        next_pc_d;
  logic                        out_of_range;
  logic                        is_halt;

  // Sign-extend the 16-bit word offset to the full PC width.
  function automatic logic signed [dataWidth-1:0] sext_offset(input logic [15:0] off);
    return $signed({{(dataWidth-16){off[15]}}, off});
  endfunction

  assign pc_inc = pc_q + dataWidth'(1);
  assign is_halt = (Instr == HALT_INSTR);

  // Next-PC select: jump beats branch beats sequential; a negative branch
  // result wraps to a large unsigned value and is caught by the range check.
  always_comb begin
    br_off_s    = sext_offset(branch_offset);
    br_target_s = $signed(pc_inc) + br_off_s;
    next_pc_d   = pc_inc;
    if (jump) begin
      next_pc_d = {{(dataWidth-26){1'b0}}, jump_target};
    end else if (branch_taken) begin
      next_pc_d = $unsigned(br_target_s);
    end
    out_of_range = |next_pc_d[dataWidth-1:addWidth];
  end

  // Fetch FSM with registered status outputs; PC only moves on a legal advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= BOOT;
      pc_q     <= RESET_PC;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      case (state_q)
        BOOT: begin
          state_q <= RUN;
          valid_q <= 1'b1;
        end
        RUN: begin
          if (!stall) begin
            if (is_halt) begin
              state_q  <= HALTED;
              valid_q  <= 1'b0;
              halted_q <= 1'b1;
            end else if (out_of_range) begin
              state_q <= FAULT;
              valid_q <= 1'b0;
              fault_q <= 1'b1;
            end else begin
              pc_q  <= next_pc_d;
              cnt_q <= cnt_q + dataWidth'(1);
            end
          end
        end
        HALTED: begin
          state_q <= HALTED;
        end
        FAULT: begin
          state_q <= FAULT;
        end
        default: begin
          state_q <= BOOT;
        end
      endcase
    end
  end

  assign PC          = pc_q;
  assign pc_plus1    = pc_inc;
  assign valid       = valid_q;
  assign halted      = halted_q;
  assign fault       = fault_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: a reference model predicts the post-edge state for
// every driven cycle, queues it, and the queued entry is compared after the edge.
module tb_pc_fetch_unit;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_offset;
  logic        jump;
  logic [25:0] jump_target;
  logic [31:0] Instr;
  logic [31:0] PC;
  logic [31:0] pc_plus1;
  logic        valid;
  logic        halted;
  logic        fault;
  logic [31:0] instr_count;

  logic [31:0] imem [0:63];

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] cnt;
    logic        v;
    logic        h;
    logic        f;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_errors = 0;

  // model state: 0 BOOT, 1 RUN, 2 HALTED, 3 FAULT
  int          m_state = 0;
  logic [31:0] m_pc    = '0;
  logic [31:0] m_cnt   = '0;

  always #5 clk = ~clk;

  assign Instr = imem[PC[5:0]];

  pc_fetch_unit #(
    .addWidth  (6),
    .dataWidth (32),
    .RESET_PC  (32'd0),
    .HALT_INSTR(HALT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_offset(branch_offset),
    .jump         (jump),
    .jump_target  (jump_target),
    .Instr        (Instr),
    .PC           (PC),
    .pc_plus1     (pc_plus1),
    .valid        (valid),
    .halted       (halted),
    .fault        (fault),
    .instr_count  (instr_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, predict the result, then compare after the edge.
  task automatic step(input logic r, input logic s, input logic b, input logic [15:0] off,
                      input logic j, input logic [25:0] tgt, input string tag);
    logic [31:0] np;
    exp_t e;
    rst = r; stall = s; branch_taken = b; branch_offset = off;
    jump = j; jump_target = tgt;
    if (r) begin
      m_state = 0; m_pc = '0; m_cnt = '0;
    end else begin
      case (m_state)
        0: m_state = 1;
        1: begin
          if (!s) begin
            if (imem[m_pc[5:0]] == HALT) begin
              m_state = 2;
            end else begin
              if (j)      np = {6'd0, tgt};
              else if (b) np = m_pc + 32'd1 + {{16{off[15]}}, off};
              else        np = m_pc + 32'd1;
              if (np >= 32'd64) m_state = 3;
              else begin
                m_pc  = np;
                m_cnt = m_cnt + 32'd1;
              end
            end
          end
        end
        default: ;
      endcase
    end
    e.pc = m_pc; e.cnt = m_cnt;
    e.v = (m_state == 1); e.h = (m_state == 2); e.f = (m_state == 3);
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check({tag, ".sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check({tag, ".PC"},       PC,          e.pc);
      check({tag, ".pc_plus1"}, pc_plus1,    e.pc + 32'd1);
      check({tag, ".count"},    instr_count, e.cnt);
      check({tag, ".valid"},    {31'd0, valid},  {31'd0, e.v});
      check({tag, ".halted"},   {31'd0, halted}, {31'd0, e.h});
      check({tag, ".fault"},    {31'd0, fault},  {31'd0, e.f});
    end
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 26'd0, tag);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 26'd0, "reset");
  endtask

  initial begin
    for (int i = 0; i < 64; i++) imem[i] = 32'h0000_0013 + i;
    imem[7] = HALT;
    rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_offset = '0;
    jump = 1'b0; jump_target = '0;
    @(negedge clk);

    // reset and boot, then sequential fetch 0..4
    do_reset(3);
    run(1, "boot");
    run(4, "seq");
    // branch back from 4 by -3 -> 2, then jump+branch together -> 10
    step(1'b0, 1'b0, 1'b1, 16'hFFFD, 1'b0, 26'd0,  "branch_back");
    step(1'b0, 1'b0, 1'b1, 16'h0005, 1'b1, 26'd10, "jump_wins");

    // stall at 5, then halt at 7 (stall first delays the halt)
    do_reset(1);
    run(1, "boot2");
    run(5, "seq2");
    step(1'b0, 1'b1, 1'b1, 16'h0003, 1'b0, 26'd0,  "stall");
    step(1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 26'd20, "stall");
    run(2, "post_stall");
    step(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 26'd0,  "stall_on_halt");
    run(1, "halt");
    step(1'b0, 1'b0, 1'b1, 16'h0002, 1'b1, 26'd3, "halted_frozen");
    run(4, "halted_frozen");
    do_reset(1);

    // sequential fetch past the top of memory
    run(1, "boot3");
    step(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 26'd60, "jump60");
    run(3, "seq_top");
    run(1, "fault_seq");
    step(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 26'd5, "fault_frozen");
    run(1, "fault_frozen");

    // negative branch below zero
    do_reset(1);
    run(1, "boot4");
    run(1, "seq4");
    step(1'b0, 1'b0, 1'b1, 16'hFFFB, 1'b0, 26'd0, "fault_neg_branch");
    run(1, "fault_frozen2");

    // mid-run reset beats a taken branch
    do_reset(1);
    run(1, "boot5");
    step(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 26'd9, "jump9");
    step(1'b1, 1'b0, 1'b1, 16'h0003, 1'b0, 26'd0, "midrun_reset");
    run(1, "boot6");
    step(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 26'd64, "fault_jump64");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
